// File: rtl/apb_slave_param_if.sv
// APB3 completer bus bundle for apb_slave_param.
// The pstrb lane-enable signal exists only when APB_PSTRB_EN is defined.
interface apb_slave_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int WAIT_W = 4
) ();
  logic [ADDR_W-1:0]   paddr;
  logic                psel;
  logic                penable;
  logic                pwrite;
  logic [DATA_W-1:0]   pwdata;
  logic [WAIT_W-1:0]   cfg_wait;
`ifdef APB_PSTRB_EN
  logic [DATA_W/8-1:0] pstrb;
`endif
  logic [DATA_W-1:0]   prdata;
  logic                pready;
  logic                pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata, cfg_wait,
`ifdef APB_PSTRB_EN
    output pstrb,
`endif
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata, cfg_wait,
`ifdef APB_PSTRB_EN
    input  pstrb,
`endif
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_slave_param.sv
// Parametrised APB3 completer: word memory, per-transfer wait states, PSLVERR on out-of-range access.
// Optional byte-lane write strobes are enabled with the APB_PSTRB_EN macro.
module apb_slave_param #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 32,
  parameter int WAIT_W = 4
) (
  input  logic             i_pclk,
  input  logic             i_presetn,
  apb_slave_param_if.slave io_apb
);
  localparam int NBYTES = DATA_W / 8;
  localparam int LSB    = $clog2(NBYTES);
  localparam int IDX_W  = ADDR_W - LSB;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  logic [DATA_W-1:0] r_mem [DEPTH];

  state_t            r_state;
  logic [WAIT_W-1:0] r_cnt;
  logic [DATA_W-1:0] r_prdata;
  logic [DATA_W-1:0] r_wdata;
  logic [MEM_AW-1:0] r_idx;
  logic              r_write;
  logic              r_err;
`ifdef APB_PSTRB_EN
  logic [NBYTES-1:0] r_strb;
`endif

  logic [IDX_W-1:0]  w_idx;
  logic [MEM_AW-1:0] w_memIdx;
  logic              w_inRange;
  logic              w_badStrb;
  logic              w_err;
  logic              w_setup;
  logic              w_commit;

  assign w_idx     = IDX_W'(io_apb.paddr >> LSB);
  assign w_memIdx  = MEM_AW'(w_idx);
  assign w_inRange = (32'(w_idx) < 32'(DEPTH));
`ifdef APB_PSTRB_EN
  // Reads must carry an all-zero strobe; anything else is flagged as an error.
  assign w_badStrb = ~io_apb.pwrite & (|io_apb.pstrb);
`else
  assign w_badStrb = 1'b0;
`endif
  assign w_err     = ~w_inRange | w_badStrb;
  assign w_setup   = io_apb.psel & ~io_apb.penable;
  assign w_commit  = (r_state == S_DONE) & io_apb.psel & r_write & ~r_err;

  always_ff @(posedge i_pclk or negedge i_presetn) begin
    if (!i_presetn) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_prdata <= '0;
      r_wdata  <= '0;
      r_idx    <= '0;
      r_write  <= 1'b0;
      r_err    <= 1'b0;
`ifdef APB_PSTRB_EN
      r_strb   <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_setup) begin
            r_idx    <= w_memIdx;
            r_write  <= io_apb.pwrite;
            r_wdata  <= io_apb.pwdata;
            r_err    <= w_err;
            r_cnt    <= io_apb.cfg_wait;
`ifdef APB_PSTRB_EN
            r_strb   <= io_apb.pstrb;
`endif
            // Read data is fetched at setup, so a later write in the same burst cannot affect it.
            r_prdata <= (!io_apb.pwrite && !w_err) ? r_mem[w_memIdx] : '0;
            r_state  <= (io_apb.cfg_wait != '0) ? S_WAIT : S_DONE;
          end
        end
        S_WAIT: begin
          if (!io_apb.psel) begin
            r_state <= S_IDLE;
          end else if (io_apb.penable) begin
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == WAIT_W'(1)) begin
              r_state <= S_DONE;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Memory is deliberately outside the reset domain; contents survive presetn.
  always_ff @(posedge i_pclk) begin
    if (w_commit) begin
`ifdef APB_PSTRB_EN
      for (int b = 0; b < NBYTES; b++) begin
        if (r_strb[b]) begin
          r_mem[r_idx][8*b +: 8] <= r_wdata[8*b +: 8];
        end
      end
`else
      r_mem[r_idx] <= r_wdata;
`endif
    end
  end

  assign io_apb.prdata  = r_prdata;
  assign io_apb.pready  = (r_state == S_DONE);
  assign io_apb.pslverr = (r_state == S_DONE) & r_err;
endmodule

// File: tb/tb_apb_slave_param.sv
// Scoreboard bench for apb_slave_param: random and directed APB transfers checked against a word-array model.
// Builds with or without APB_PSTRB_EN.
module tb_apb_slave_param;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 32;
  localparam int WAIT_W = 4;

  logic clk     = 1'b0;
  logic presetn = 1'b0;
  always #5 clk = ~clk;

  apb_slave_param_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .WAIT_W(WAIT_W)) apbIf ();

  apb_slave_param #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH),
    .WAIT_W(WAIT_W)
  ) dut (
    .i_pclk   (clk),
    .i_presetn(presetn),
    .io_apb   (apbIf)
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          doneCycle;
    string       tag;
  } exp_t;

  exp_t        expQ[$];
  logic [31:0] refMem[DEPTH];
  int          checks     = 0;
  int          failures   = 0;
  int          cycleCount = 0;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] mergeLanes(input logic [31:0] oldW, input logic [31:0] newW,
                                             input logic [3:0] strb);
    logic [31:0] r;
    r = oldW;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = newW[8*b +: 8];
    return r;
  endfunction

  // Monitor: every completion pops one expected response.
  always @(negedge clk) begin
    exp_t e;
    if (presetn && apbIf.pready === 1'b1) begin
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_pready: actual pready=1 at cycle %0d, required no completion", cycleCount);
      end else begin
        e = expQ.pop_front();
        checkOutput({e.tag, "_prdata"},  apbIf.prdata,          e.data);
        checkOutput({e.tag, "_pslverr"}, 32'(apbIf.pslverr),    32'(e.err));
        checkOutput({e.tag, "_latency"}, 32'(cycleCount),       32'(e.doneCycle));
      end
    end
  end

  // mode 0: complete normally, 1: drop psel after k access cycles, 2: pulse reset after k access cycles.
  task automatic applyStimulus(input bit wr, input logic [7:0] addr, input logic [31:0] data,
                               input int nWait, input logic [3:0] strb, input int mode,
                               input int k, input string tag);
    int          idx;
    int          g;
    logic        err;
    logic [3:0]  effStrb;
    exp_t        e;
    idx = int'(addr) / (DATA_W / 8);
    err = (idx >= DEPTH);
`ifdef APB_PSTRB_EN
    if (!wr && strb != 4'h0) err = 1'b1;
    effStrb = strb;
`else
    effStrb = strb | 4'hF;
`endif
    @(posedge clk);
    #1;
    apbIf.psel     = 1'b1;
    apbIf.penable  = 1'b0;
    apbIf.pwrite   = wr;
    apbIf.paddr    = addr;
    apbIf.pwdata   = data;
    apbIf.cfg_wait = WAIT_W'(nWait);
`ifdef APB_PSTRB_EN
    apbIf.pstrb    = strb;
`endif
    if (mode == 0) begin
      e.data      = (wr || err) ? 32'h0 : refMem[idx];
      e.err       = err;
      e.doneCycle = cycleCount + 1 + nWait;
      e.tag       = tag;
      expQ.push_back(e);
      if (wr && !err) refMem[idx] = mergeLanes(refMem[idx], data, effStrb);
    end
    @(posedge clk);
    #1;
    apbIf.penable  = 1'b1;
    apbIf.paddr    = 8'($urandom);
    apbIf.pwdata   = $urandom;
    apbIf.cfg_wait = WAIT_W'($urandom);
`ifdef APB_PSTRB_EN
    apbIf.pstrb    = 4'($urandom);
`endif
    if (mode == 1) begin
      repeat (k) @(posedge clk);
      #1;
      apbIf.psel    = 1'b0;
      apbIf.penable = 1'b0;
    end else if (mode == 2) begin
      repeat (k) @(posedge clk);
      #2;
      presetn = 1'b0;
      #1;
      checkOutput({tag, "_rst_pready"},  32'(apbIf.pready),  32'h0);
      checkOutput({tag, "_rst_pslverr"}, 32'(apbIf.pslverr), 32'h0);
      checkOutput({tag, "_rst_prdata"},  apbIf.prdata,       32'h0);
      apbIf.psel    = 1'b0;
      apbIf.penable = 1'b0;
      @(posedge clk);
      #2;
      presetn = 1'b1;
    end else begin
      g = 0;
      @(negedge clk);
      while (apbIf.pready !== 1'b1 && g < 64) begin
        @(negedge clk);
        g++;
      end
      if (apbIf.pready !== 1'b1) begin
        checks++;
        failures++;
        $display("[TB] FAIL %s_timeout: actual pready=%b after 64 cycles, required 1", tag, apbIf.pready);
      end
    end
  endtask

  task automatic idleCycles(input int n);
    @(posedge clk);
    #1;
    apbIf.psel    = 1'b0;
    apbIf.penable = 1'b0;
    repeat (n - 1) @(posedge clk);
  endtask

  task automatic printSummary();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
  endtask

  initial begin
    #400000;
    checks++;
    failures++;
    $display("[TB] FAIL watchdog: actual=simulation still running, required=finished");
    printSummary();
    $finish;
  end

  initial begin
    bit         wr;
    logic [3:0] strb;
    apbIf.psel     = 1'b0;
    apbIf.penable  = 1'b0;
    apbIf.pwrite   = 1'b0;
    apbIf.paddr    = '0;
    apbIf.pwdata   = '0;
    apbIf.cfg_wait = '0;
`ifdef APB_PSTRB_EN
    apbIf.pstrb    = '0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_pready",  32'(apbIf.pready),  32'h0);
    checkOutput("reset_pslverr", 32'(apbIf.pslverr), 32'h0);
    checkOutput("reset_prdata",  apbIf.prdata,       32'h0);
    @(posedge clk);
    #2;
    presetn = 1'b1;

    // Fill every word back-to-back so later reads are defined.
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 8'(i * 4), $urandom, 0, 4'hF, 0, 0, "init");
    idleCycles(1);

    applyStimulus(1'b1, 8'h08, 32'hDEADBEEF, 0, 4'hF, 0, 0, "wr08");
    applyStimulus(1'b0, 8'h08, 32'h0,        0, 4'h0, 0, 0, "rd08");
    applyStimulus(1'b1, 8'h10, 32'h12345678, 3, 4'hF, 0, 0, "wr10");
    applyStimulus(1'b0, 8'h10, 32'h0,        5, 4'h0, 0, 0, "rd10");
    applyStimulus(1'b1, 8'h80, 32'hFFFFFFFF, 1, 4'hF, 0, 0, "wr80");
    applyStimulus(1'b0, 8'h80, 32'h0,        0, 4'h0, 0, 0, "rd80");
    applyStimulus(1'b0, 8'h00, 32'h0,        0, 4'h0, 0, 0, "rd00");
    applyStimulus(1'b0, 8'hFF, 32'h0,        2, 4'h0, 0, 0, "rdFF");
    applyStimulus(1'b0, 8'h0B, 32'h0,        0, 4'h0, 0, 0, "rd0B");
    idleCycles(2);

    applyStimulus(1'b1, 8'h04, 32'h0,        0, 4'hF, 0, 0, "wr04");
    idleCycles(1);
    applyStimulus(1'b1, 8'h04, 32'hCAFEF00D, 4, 4'hF, 1, 1, "abort04");
    repeat (6) begin
      @(negedge clk);
      checkOutput("abort_nopready", 32'(apbIf.pready), 32'h0);
    end
    applyStimulus(1'b0, 8'h04, 32'h0,        0, 4'h0, 0, 0, "rd04");
    idleCycles(1);

    applyStimulus(1'b1, 8'h0C, 32'h55AA55AA, 5, 4'hF, 2, 2, "rstWait");
    applyStimulus(1'b0, 8'h0C, 32'h0,        1, 4'h0, 0, 0, "rd0C");
    idleCycles(1);
    applyStimulus(1'b1, 8'h18, 32'hA5A5A5A5, 0, 4'hF, 2, 0, "rstDone");
    applyStimulus(1'b0, 8'h18, 32'h0,        0, 4'h0, 0, 0, "rd18");

    // psel with penable in IDLE is a protocol violation and must be ignored.
    @(posedge clk);
    #1;
    apbIf.psel    = 1'b1;
    apbIf.penable = 1'b1;
    apbIf.pwrite  = 1'b1;
    apbIf.paddr   = 8'h08;
    apbIf.pwdata  = 32'h0BADF00D;
    repeat (3) begin
      @(negedge clk);
      checkOutput("violation_nopready", 32'(apbIf.pready), 32'h0);
    end
    idleCycles(1);
    applyStimulus(1'b0, 8'h08, 32'h0,        0, 4'h0, 0, 0, "rd08b");

    applyStimulus(1'b0, 8'h14, 32'h0,        2, 4'h0, 0, 0, "rd14");
    applyStimulus(1'b1, 8'h14, 32'h13572468, 0, 4'hF, 0, 0, "wr14");
    applyStimulus(1'b0, 8'h14, 32'h0,        0, 4'h0, 0, 0, "rd14b");

`ifdef APB_PSTRB_EN
    applyStimulus(1'b1, 8'h00, 32'hAABBCCDD, 0, 4'hF, 0, 0, "strbInit");
    applyStimulus(1'b1, 8'h00, 32'h11223344, 1, 4'h5, 0, 0, "strbWr");
    applyStimulus(1'b0, 8'h00, 32'h0,        0, 4'h0, 0, 0, "strbRd");
    applyStimulus(1'b1, 8'h00, 32'hFFFFFFFF, 0, 4'h0, 0, 0, "strbZero");
    applyStimulus(1'b0, 8'h00, 32'h0,        0, 4'h0, 0, 0, "strbRd2");
    applyStimulus(1'b0, 8'h00, 32'h0,        0, 4'h1, 0, 0, "strbBadRd");
`endif
    idleCycles(1);

    repeat (80) begin
      wr = 1'($urandom_range(0, 1));
`ifdef APB_PSTRB_EN
      strb = wr ? 4'($urandom) : (($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'h0);
`else
      strb = 4'($urandom);
`endif
      applyStimulus(wr, 8'($urandom_range(0, 8'h8F)), $urandom, $urandom_range(0, 6), strb, 0, 0, "rnd");
      if ($urandom_range(0, 2) == 0) idleCycles($urandom_range(1, 3));
    end

    idleCycles(3);
    checkOutput("queue_empty", 32'(expQ.size()), 32'h0);
    printSummary();
    $finish;
  end
endmodule
